// File: rtl/instr_sequencer_pkg.sv
// Shared widths, default parameters and state encoding for the instruction sequencer.
package instr_sequencer_pkg;

  localparam int SEQ_DEPTH   = 8;
  localparam int SEQ_ADDR_W  = 3;
  localparam int SEQ_TIMEOUT = 64;
  localparam int OPCODE_W    = 4;
  localparam int OPERAND_W   = 12;
  localparam int WORD_W      = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] SEQ_HALT_OP = 4'h7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_HALT      = 3'd4,
    S_ERROR     = 3'd5
  } seq_state_e;

  function automatic logic [OPCODE_W-1:0] word_opcode(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: OPCODE_W];
  endfunction

  function automatic logic [OPERAND_W-1:0] word_operand(input logic [WORD_W-1:0] w);
    return w[OPERAND_W-1:0];
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_buffer.sv
// Program store: DEPTH x 16-bit register array, one synchronous write port and
// one asynchronous read port. Contents are not reset.
import instr_sequencer_pkg::*;

module prog_buffer #(
  parameter int DEPTH  = SEQ_DEPTH,
  parameter int ADDR_W = SEQ_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer in front of cpu_core: byte-serial program capture, then one-at-a-time
// issue with retire handshake, single-step, halt opcode and a retire watchdog.
import instr_sequencer_pkg::*;

module instr_sequencer #(
  parameter int                  DEPTH   = SEQ_DEPTH,
  parameter int                  ADDR_W  = SEQ_ADDR_W,
  parameter int                  TIMEOUT = SEQ_TIMEOUT,
  parameter logic [OPCODE_W-1:0] HALT_OP = SEQ_HALT_OP
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_en_i,
  input  logic [7:0]           data_in_i,
  input  logic                 data_valid_i,
  input  logic                 run_start_i,
  input  logic                 step_mode_i,
  input  logic                 core_done_i,
  output logic [OPCODE_W-1:0]  opcode_o,
  output logic [OPERAND_W-1:0] instr_o,
  output logic                 inst_done_o,
  output logic [ADDR_W-1:0]    pc_o,
  output logic [ADDR_W:0]      prog_len_o,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 error_o
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

  seq_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [ADDR_W:0]      prog_len_q, prog_len_d;
  logic [7:0]           hi_q, hi_d;
  logic                 phase_q, phase_d;
  logic                 load_en_q;
  logic                 core_done_q;
  logic [OPCODE_W-1:0]  opcode_q, opcode_d;
  logic [OPERAND_W-1:0] instr_q, instr_d;
  logic                 inst_done_q, inst_done_d;
  logic                 busy_q, halted_q, error_q;

  logic                 load_rise;
  logic [ADDR_W:0]      len_base;
  logic                 phase_base;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WORD_W-1:0]    wr_data;
  logic [WORD_W-1:0]    rd_word;
  logic [ADDR_W:0]      last_idx;

  prog_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_buffer (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (pc_q),
    .rdata_o (rd_word)
  );

  // Byte assembler. The write pointer is the low bits of prog_len, so a full buffer never wraps.
  always_comb begin
    load_rise  = load_en_i & ~load_en_q;
    len_base   = load_rise ? '0 : prog_len_q;
    phase_base = load_rise ? 1'b0 : phase_q;
    prog_len_d = len_base;
    phase_d    = phase_base;
    hi_d       = hi_q;
    wr_en      = 1'b0;
    wr_addr    = len_base[ADDR_W-1:0];
    wr_data    = {hi_q, data_in_i};
    if (!load_en_i) begin
      phase_d = 1'b0;
    end else if (state_q == S_IDLE && data_valid_i && len_base < LEN_FULL) begin
      if (!phase_base) begin
        hi_d    = data_in_i;
        phase_d = 1'b1;
      end else begin
        wr_en      = 1'b1;
        prog_len_d = len_base + LEN_ONE;
        phase_d    = 1'b0;
      end
    end
  end

  assign last_idx = prog_len_q - LEN_ONE;

  // Retire strobe is registered on its way into WAIT, giving a two-edge retire-to-issue path.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wd_d        = wd_q;
    opcode_d    = opcode_q;
    instr_d     = instr_q;
    inst_done_d = 1'b0;
    if (load_en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_start_i && prog_len_q != '0) begin
            state_d = S_ISSUE;
            pc_d    = '0;
          end
        end
        S_ISSUE: begin
          if (word_opcode(rd_word) == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            opcode_d    = word_opcode(rd_word);
            instr_d     = word_operand(rd_word);
            inst_done_d = 1'b1;
            wd_d        = '0;
            state_d     = S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_done_q) begin
            if ({1'b0, pc_q} == last_idx) begin
              state_d = S_HALT;
            end else begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = step_mode_i ? S_STEP_WAIT : S_ISSUE;
            end
          end else if (wd_q == WD_MAX) begin
            state_d = S_ERROR;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        S_STEP_WAIT: begin
          if (run_start_i) begin
            state_d = S_ISSUE;
          end
        end
        S_HALT, S_ERROR: begin
          if (run_start_i) begin
            state_d = S_ISSUE;
            pc_d    = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      wd_q        <= '0;
      prog_len_q  <= '0;
      hi_q        <= '0;
      phase_q     <= 1'b0;
      load_en_q   <= 1'b0;
      core_done_q <= 1'b0;
      opcode_q    <= '0;
      instr_q     <= '0;
      inst_done_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wd_q        <= wd_d;
      prog_len_q  <= prog_len_d;
      hi_q        <= hi_d;
      phase_q     <= phase_d;
      load_en_q   <= load_en_i;
      core_done_q <= core_done_i && (state_q == S_WAIT);
      opcode_q    <= opcode_d;
      instr_q     <= instr_d;
      inst_done_q <= inst_done_d;
      busy_q      <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_STEP_WAIT);
      halted_q    <= (state_d == S_HALT);
      error_q     <= (state_d == S_ERROR);
    end
  end

  assign opcode_o    = opcode_q;
  assign instr_o     = instr_q;
  assign inst_done_o = inst_done_q;
  assign pc_o        = pc_q;
  assign prog_len_o  = prog_len_q;
  assign busy_o      = busy_q;
  assign halted_o    = halted_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of programs run against an issue scoreboard,
// plus hand-written sequences for latency, watchdog, partial load and async reset.
module tb_instr_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int NV      = 6;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        load_en    = 1'b0;
  logic [7:0]  data_in    = 8'h00;
  logic        data_valid = 1'b0;
  logic        run_start  = 1'b0;
  logic        step_mode  = 1'b0;
  logic        respDone   = 1'b0;
  logic        manualDone = 1'b0;
  logic        core_done;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic [2:0]  pc;
  logic [3:0]  prog_len;
  logic        busy, halted, error;

  assign core_done = respDone | manualDone;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .load_en_i    (load_en),
    .data_in_i    (data_in),
    .data_valid_i (data_valid),
    .run_start_i  (run_start),
    .step_mode_i  (step_mode),
    .core_done_i  (core_done),
    .opcode_o     (opcode),
    .instr_o      (instr),
    .inst_done_o  (inst_done),
    .pc_o         (pc),
    .prog_len_o   (prog_len),
    .busy_o       (busy),
    .halted_o     (halted),
    .error_o      (error)
  );

  typedef struct {
    string            name;
    logic [8:0][15:0] words;
    int               n;
    bit               step;
    int               expIssues;
    int               expPc;
    int               expLen;
  } vec_t;

  vec_t             vecs [NV];
  logic [15:0]      expQ [$];
  logic [15:0]      expWord;
  logic [8:0][15:0] w;
  int  checks        = 0;
  int  errors        = 0;
  int  issueCount    = 0;
  int  retireCount   = 0;
  int  respCountdown = 0;
  bit  autoRetire    = 1'b0;
  bit  prevInstDone  = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue monitor: every inst_done pops the scoreboard; the pulse must last one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prevInstDone) checkOutput("inst_done_one_cycle", int'(inst_done), 0);
      if (inst_done) begin
        issueCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_issue: got 0x%04h, expected no issue", {opcode, instr});
        end else begin
          expWord = expQ.pop_front();
          checkOutput("issue_word", int'({opcode, instr}), int'(expWord));
        end
        if (autoRetire) respCountdown = 4;
      end
    end
    prevInstDone = inst_done;
  end

  // Core model: retire strobe four cycles after each observed issue.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      respCountdown = 0;
      respDone      = 1'b0;
    end else if (respCountdown == 1) begin
      respDone = 1'b1;
      retireCount++;
      respCountdown = 0;
    end else begin
      respDone = 1'b0;
      if (respCountdown > 0) respCountdown--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseRunStart();
    tick();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [8:0][15:0] words, input int n, input bit extraByte);
    tick();
    load_en    = 1'b1;
    data_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      data_in    = words[i][15:8];
      data_valid = 1'b1;
      tick();
      data_in    = words[i][7:0];
    end
    if (extraByte) begin
      tick();
      data_in    = 8'hEE;
      data_valid = 1'b1;
    end
    tick();
    data_valid = 1'b0;
    load_en    = 1'b0;
    tick();
  endtask

  task automatic pushExpected(input logic [8:0][15:0] words, input int n);
    int m;
    m = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < m; i++) begin
      if (words[i][15:12] == 4'h7) break;
      expQ.push_back(words[i]);
    end
  endtask

  task automatic waitIssue(input string name);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!inst_done && g < 50);
    if (!inst_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no inst_done, expected one within 50 cycles", name);
    end
  endtask

  task automatic runProgram(input bit step);
    int seenRetire;
    int issuesAtRetire;
    int guard;
    seenRetire = retireCount;
    pulseRunStart();
    guard = 0;
    while (!halted && !error && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (step && retireCount != seenRetire) begin
        seenRetire     = retireCount;
        issuesAtRetire = issueCount;
        repeat (5) @(negedge clk);
        if (!halted) begin
          checkOutput("step_wait_busy", int'(busy), 1);
          checkOutput("step_wait_no_issue", issueCount, issuesAtRetire);
          pulseRunStart();
        end
      end
    end
    if (guard >= 3000) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout: got no halt/error, expected within 3000 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int v = 0; v < NV; v++) vecs[v].words = '0;
    vecs[0].name = "free_run";    vecs[0].words[0] = 16'h8123; vecs[0].words[1] = 16'h0456;
    vecs[0].words[2] = 16'h9789;  vecs[0].n = 3; vecs[0].step = 0;
    vecs[0].expIssues = 3; vecs[0].expPc = 2; vecs[0].expLen = 3;
    vecs[1] = vecs[0];
    vecs[1].name = "single_step"; vecs[1].step = 1;
    vecs[2].name = "halt_op";     vecs[2].words[0] = 16'h8001; vecs[2].words[1] = 16'h7000;
    vecs[2].words[2] = 16'h8002;  vecs[2].n = 3; vecs[2].step = 0;
    vecs[2].expIssues = 1; vecs[2].expPc = 1; vecs[2].expLen = 3;
    vecs[3].name = "halt_first";  vecs[3].words[0] = 16'h7123; vecs[3].n = 1; vecs[3].step = 0;
    vecs[3].expIssues = 0; vecs[3].expPc = 0; vecs[3].expLen = 1;
    vecs[4].name = "one_word_step"; vecs[4].words[0] = 16'hA5A5; vecs[4].n = 1; vecs[4].step = 1;
    vecs[4].expIssues = 1; vecs[4].expPc = 0; vecs[4].expLen = 1;
    vecs[5].name = "overflow9";   vecs[5].n = 9; vecs[5].step = 0;
    for (int i = 0; i < 9; i++) vecs[5].words[i] = {4'h8 ^ 4'(i), 12'(i * 273)};
    vecs[5].expIssues = 8; vecs[5].expPc = 7; vecs[5].expLen = 8;

    // Reset values
    repeat (3) tick();
    checkOutput("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_opcode", int'(opcode), 0);
    checkOutput("reset_instr", int'(instr), 0);
    checkOutput("reset_inst_done", int'(inst_done), 0);
    checkOutput("reset_pc", int'(pc), 0);
    checkOutput("reset_prog_len", int'(prog_len), 0);
    checkOutput("reset_halted", int'(halted), 0);
    checkOutput("reset_error", int'(error), 0);

    // run_start with an empty buffer is ignored
    pulseRunStart();
    repeat (3) @(negedge clk);
    checkOutput("empty_run_busy", int'(busy), 0);

    // Table-driven programs
    for (int v = 0; v < NV; v++) begin
      int issuesBefore;
      autoRetire = 1'b1;
      step_mode  = vecs[v].step;
      applyStimulus(vecs[v].words, vecs[v].n, 1'b0);
      checkOutput({vecs[v].name, "_prog_len"}, int'(prog_len), vecs[v].expLen);
      issuesBefore = issueCount;
      pushExpected(vecs[v].words, vecs[v].n);
      runProgram(vecs[v].step);
      repeat (2) @(negedge clk);
      checkOutput({vecs[v].name, "_halted"}, int'(halted), 1);
      checkOutput({vecs[v].name, "_error"}, int'(error), 0);
      checkOutput({vecs[v].name, "_busy"}, int'(busy), 0);
      checkOutput({vecs[v].name, "_pc"}, int'(pc), vecs[v].expPc);
      checkOutput({vecs[v].name, "_issues"}, issueCount - issuesBefore, vecs[v].expIssues);
      checkOutput({vecs[v].name, "_pending"}, expQ.size(), 0);
      expQ.delete();
    end
    step_mode = 1'b0;

    // Start and retire latency
    autoRetire = 1'b0;
    w = '0;
    w[0] = 16'h3ABC;
    w[1] = 16'h4DEF;
    applyStimulus(w, 2, 1'b0);
    expQ.push_back(16'h3ABC);
    expQ.push_back(16'h4DEF);
    pulseRunStart();
    @(negedge clk);
    checkOutput("start_lat_edge1", int'(inst_done), 0);
    @(negedge clk);
    checkOutput("start_lat_edge2", int'(inst_done), 1);
    tick();
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    @(negedge clk);
    checkOutput("retire_lat_edge0", int'(inst_done), 0);
    @(negedge clk);
    checkOutput("retire_lat_edge1", int'(inst_done), 0);
    @(negedge clk);
    checkOutput("retire_lat_edge2", int'(inst_done), 1);
    checkOutput("retire_lat_pc", int'(pc), 1);
    tick();
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    repeat (4) tick();
    checkOutput("retire_last_halted", int'(halted), 1);
    checkOutput("retire_last_pc", int'(pc), 1);

    // Watchdog, restart from ERROR, load_en while busy
    w = '0;
    w[0] = 16'h8123;
    applyStimulus(w, 1, 1'b0);
    expQ.push_back(16'h8123);
    pulseRunStart();
    waitIssue("wd_first_issue");
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("wd_error_before", int'(error), 0);
    checkOutput("wd_busy_before", int'(busy), 1);
    @(negedge clk);
    checkOutput("wd_error_at", int'(error), 1);
    checkOutput("wd_busy_at", int'(busy), 0);
    expQ.push_back(16'h8123);
    pulseRunStart();
    checkOutput("wd_restart_error", int'(error), 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wd_restart_issue", int'(inst_done), 1);
    checkOutput("wd_restart_pc", int'(pc), 0);
    tick();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    checkOutput("load_force_busy", int'(busy), 0);
    checkOutput("load_hold_opcode", int'(opcode), 8);
    checkOutput("load_hold_instr", int'(instr), 12'h123);

    // Partial word dropped when load_en falls
    autoRetire = 1'b1;
    w = '0;
    w[0] = 16'h5A11;
    applyStimulus(w, 1, 1'b1);
    checkOutput("partial_prog_len", int'(prog_len), 1);
    pushExpected(w, 1);
    runProgram(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("partial_halted", int'(halted), 1);
    checkOutput("partial_pending", expQ.size(), 0);

    // Async reset while waiting for retire, then a stray core_done in IDLE
    autoRetire = 1'b0;
    w = '0;
    w[0] = 16'hC0DE;
    applyStimulus(w, 1, 1'b0);
    expQ.push_back(16'hC0DE);
    pulseRunStart();
    waitIssue("areset_issue");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_busy", int'(busy), 0);
    checkOutput("areset_inst_done", int'(inst_done), 0);
    checkOutput("areset_opcode", int'(opcode), 0);
    checkOutput("areset_instr", int'(instr), 0);
    checkOutput("areset_pc", int'(pc), 0);
    checkOutput("areset_prog_len", int'(prog_len), 0);
    tick();
    rst_n = 1'b1;
    w = '0;
    w[0] = 16'h8123;
    w[1] = 16'h0456;
    applyStimulus(w, 2, 1'b0);
    begin
      int issuesBefore;
      issuesBefore = issueCount;
      tick();
      manualDone = 1'b1;
      tick();
      manualDone = 1'b0;
      repeat (3) tick();
      checkOutput("stray_done_busy", int'(busy), 0);
      checkOutput("stray_done_halted", int'(halted), 0);
      checkOutput("stray_done_pc", int'(pc), 0);
      checkOutput("stray_done_issues", issueCount - issuesBefore, 0);
    end
    autoRetire = 1'b1;
    pushExpected(w, 2);
    runProgram(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("post_reset_halted", int'(halted), 1);
    checkOutput("post_reset_pc", int'(pc), 1);
    checkOutput("post_reset_pending", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
